// File: rtl/din_frame_loader.sv
// din_frame_loader
//
// Byte-stream front end for the DIN/CLK/SYN serial pattern shifter. Opcodes
// arrive over a valid/ready byte interface. A LOAD assembles a TOTAL_BITS-bit
// pattern, LSB first, into a shadow register. FIRE and CLEAR commands wait
// until the shifter is idle, commit to the shifter-facing outputs and then
// pulse trig once. data_reg, clr_mode and clr_2_one change only in that
// commit cycle, so they never move under a running shift.
//
// Opcodes (accepted in IDLE): 0x01 LOAD, 0x02 FIRE, 0x03 CLEAR_ZERO,
// 0x04 CLEAR_ONE, 0x05 CLEAR_ERR; any other value sets err.
//
// Optional feature macro: DIN_LOADER_CHKSUM_EN. When it is defined, a LOAD
// takes one extra trailing byte that must equal the XOR of the payload bytes.
//
// Ports:
//   clk_in      in   system clock, posedge
//   rst         in   asynchronous active-high reset
//   byte_valid  in   input byte present
//   byte_data   in   input byte [7:0]
//   byte_ready  out  loader accepts a byte this cycle
//   busy        in   shifter out_en (asynchronous, 2-flop synchronized)
//   data_reg    out  committed pattern [TOTAL_BITS-1:0]
//   trig        out  one-cycle trigger pulse
//   clr_mode    out  shifter clear-mode select
//   clr_2_one   out  clear level (1 = ones, 0 = zeros)
//   frame_valid out  shadow holds a complete accepted frame
//   err         out  sticky error flag
module din_frame_loader #(
    parameter int unsigned TOTAL_BITS  = 620,
    parameter int unsigned NBYTES      = 78,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  busy,
    output logic [TOTAL_BITS-1:0] data_reg,
    output logic                  trig,
    output logic                  clr_mode,
    output logic                  clr_2_one,
    output logic                  frame_valid,
    output logic                  err
);

    localparam int unsigned CntW = 7;
    localparam int unsigned AckW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [AckW-1:0] AckLast = AckW'(ACK_TIMEOUT - 1);
`ifdef DIN_LOADER_CHKSUM_EN
    // The checksum byte follows the payload, so the last index is NBYTES.
    localparam logic [CntW-1:0] LastIdx = CntW'(NBYTES);
`else
    localparam logic [CntW-1:0] LastIdx = CntW'(NBYTES - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitIdle,
        StFire,
        StWaitAck
    } state_e;

    state_e                state_q, state_d;
    logic                  busy_meta_q, busy_s_q;
    logic [TOTAL_BITS-1:0] shadow_q, shadow_d;
    logic [TOTAL_BITS-1:0] data_reg_q, data_reg_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [AckW-1:0]       ack_cnt_q, ack_cnt_d;
    logic                  pend_clr_q, pend_clr_d;
    logic                  pend_lvl_q, pend_lvl_d;
    logic                  trig_q, trig_d;
    logic                  clr_mode_q, clr_mode_d;
    logic                  clr_2_one_q, clr_2_one_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  err_q, err_d;
    logic                  xfer;
    logic [CntW+2:0]       bit_idx;
`ifdef DIN_LOADER_CHKSUM_EN
    logic [7:0]            chk_q, chk_d;
`endif

    assign byte_ready = ((state_q == StIdle) || (state_q == StLoad)) && !rst;
    assign xfer       = byte_valid && byte_ready;

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        data_reg_d    = data_reg_q;
        cnt_d         = cnt_q;
        ack_cnt_d     = ack_cnt_q;
        pend_clr_d    = pend_clr_q;
        pend_lvl_d    = pend_lvl_q;
        trig_d        = 1'b0;
        clr_mode_d    = clr_mode_q;
        clr_2_one_d   = clr_2_one_q;
        frame_valid_d = frame_valid_q;
        err_d         = err_q;
        bit_idx       = '0;
`ifdef DIN_LOADER_CHKSUM_EN
        chk_d         = chk_q;
`endif

        case (state_q)
            StIdle: begin
                if (xfer) begin
                    case (byte_data)
                        8'h01: begin
                            frame_valid_d = 1'b0;
                            cnt_d         = '0;
`ifdef DIN_LOADER_CHKSUM_EN
                            chk_d         = '0;
`endif
                            state_d       = StLoad;
                        end
                        8'h02: begin
                            if (!frame_valid_q) begin
                                err_d = 1'b1;
                            end else begin
                                pend_clr_d = 1'b0;
                                state_d    = StWaitIdle;
                            end
                        end
                        8'h03, 8'h04: begin
                            pend_clr_d = 1'b1;
                            pend_lvl_d = ~byte_data[0];
                            state_d    = StWaitIdle;
                        end
                        8'h05:   err_d = 1'b0;
                        default: err_d = 1'b1;
                    endcase
                end
            end

            StLoad: begin
                if (xfer) begin
                    // LSB first: the shifter emits bit 0 first. Bits past the
                    // pattern end (tail of the last byte, checksum) are dropped.
                    for (int j = 0; j < 8; j++) begin
                        bit_idx = {cnt_q, 3'(j)};
                        if (32'(bit_idx) < TOTAL_BITS) begin
                            shadow_d[bit_idx] = byte_data[j];
                        end
                    end
                    if (cnt_q == LastIdx) begin
`ifdef DIN_LOADER_CHKSUM_EN
                        if (byte_data == chk_q) begin
                            frame_valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
`else
                        frame_valid_d = 1'b1;
`endif
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
`ifdef DIN_LOADER_CHKSUM_EN
                        chk_d = chk_q ^ byte_data;
`endif
                    end
                end
            end

            StWaitIdle: begin
                if (!busy_s_q) begin
                    if (pend_clr_q) begin
                        clr_mode_d  = 1'b1;
                        clr_2_one_d = pend_lvl_q;
                    end else begin
                        data_reg_d = shadow_q;
                        clr_mode_d = 1'b0;
                    end
                    state_d = StFire;
                end
            end

            StFire: begin
                // trig is registered, so it rises one cycle after the commit.
                trig_d    = 1'b1;
                ack_cnt_d = '0;
                state_d   = StWaitAck;
            end

            StWaitAck: begin
                if (busy_s_q) begin
                    state_d = StIdle;
                end else if (ack_cnt_q == AckLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    ack_cnt_d = ack_cnt_q + AckW'(1);
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            busy_meta_q   <= 1'b0;
            busy_s_q      <= 1'b0;
            shadow_q      <= '0;
            data_reg_q    <= '0;
            cnt_q         <= '0;
            ack_cnt_q     <= '0;
            pend_clr_q    <= 1'b0;
            pend_lvl_q    <= 1'b0;
            trig_q        <= 1'b0;
            clr_mode_q    <= 1'b0;
            clr_2_one_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
`ifdef DIN_LOADER_CHKSUM_EN
            chk_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            busy_meta_q   <= busy;
            busy_s_q      <= busy_meta_q;
            shadow_q      <= shadow_d;
            data_reg_q    <= data_reg_d;
            cnt_q         <= cnt_d;
            ack_cnt_q     <= ack_cnt_d;
            pend_clr_q    <= pend_clr_d;
            pend_lvl_q    <= pend_lvl_d;
            trig_q        <= trig_d;
            clr_mode_q    <= clr_mode_d;
            clr_2_one_q   <= clr_2_one_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
`ifdef DIN_LOADER_CHKSUM_EN
            chk_q         <= chk_d;
`endif
        end
    end

    assign data_reg    = data_reg_q;
    assign trig        = trig_q;
    assign clr_mode    = clr_mode_q;
    assign clr_2_one   = clr_2_one_q;
    assign frame_valid = frame_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_din_frame_loader.sv
// Testbench for din_frame_loader: table of single-opcode IDLE vectors plus
// hand-written sequences for LOAD, FIRE, busy hold-off, CLEAR, ack timeout,
// mid-LOAD reset and (when DIN_LOADER_CHKSUM_EN is defined) the checksum.
module tb_din_frame_loader;

    localparam int TB = 620;
    localparam int NB = 78;
`ifdef DIN_LOADER_CHKSUM_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          busy;
    logic [TB-1:0] data_reg;
    logic          trig;
    logic          clr_mode;
    logic          clr_2_one;
    logic          frame_valid;
    logic          err;

    int n_cmp  = 0;
    int n_fail = 0;

    din_frame_loader #(
        .TOTAL_BITS (TB),
        .NBYTES     (NB),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .busy       (busy),
        .data_reg   (data_reg),
        .trig       (trig),
        .clr_mode   (clr_mode),
        .clr_2_one  (clr_2_one),
        .frame_valid(frame_valid),
        .err        (err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] op;
        logic       exp_err;
        logic       exp_fv;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_pat(input string name, input logic [TB-1:0] act,
                           input logic [TB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Returns 1 ns after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_in);
        byte_valid = 1'b1;
        byte_data  = b;
        chk("byte_ready_at_xfer", byte_ready, 1);
        @(posedge clk_in);
        #1;
        byte_valid = 1'b0;
    endtask

    function automatic logic [7:0] pat_byte(input int mul, input int add, input int k);
        return 8'(k * mul + add);
    endfunction

    function automatic logic [TB-1:0] pat_model(input int mul, input int add);
        logic [TB-1:0] p;
        logic [7:0]    b;
        p = '0;
        for (int k = 0; k < NB; k++) begin
            b = pat_byte(mul, add, k);
            for (int j = 0; j < 8; j++) begin
                if (k * 8 + j < TB) p[k * 8 + j] = b[j];
            end
        end
        return p;
    endfunction

    // Sends payload bytes 0..count-1 (LOAD opcode must already be accepted).
    task automatic send_payload(input int mul, input int add, input int count);
        for (int k = 0; k < count; k++) begin
            send_byte(pat_byte(mul, add, k));
            chk("fv_during_load", frame_valid, (k == NB - 1) && !ChkEn);
        end
    endtask

    task automatic send_chk(input int mul, input int add, input logic bad);
        logic [7:0] x;
        x = '0;
        for (int k = 0; k < NB; k++) x ^= pat_byte(mul, add, k);
        send_byte(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic load_frame(input int mul, input int add);
        send_byte(8'h01);
        chk("fv_cleared_by_load", frame_valid, 0);
        send_payload(mul, add, NB);
        if (ChkEn) send_chk(mul, add, 1'b0);
        chk("fv_after_load", frame_valid, 1);
        chk("err_after_load", err, 0);
    endtask

    // Called 1 ns after the edge where trig rose: shifter acknowledges, runs briefly.
    task automatic ack_and_idle();
        busy = 1'b1;
        repeat (3) tick();
        chk("ack_exit_ready", byte_ready, 1);
        chk("ack_no_err", err, 0);
        busy = 1'b0;
        repeat (3) tick();
    endtask

    logic [TB-1:0] exp1, exp2;

    initial begin
        vecs[0] = '{op: 8'h02, exp_err: 1'b1, exp_fv: 1'b0};
        vecs[1] = '{op: 8'h05, exp_err: 1'b0, exp_fv: 1'b0};
        vecs[2] = '{op: 8'h7F, exp_err: 1'b1, exp_fv: 1'b0};
        vecs[3] = '{op: 8'h05, exp_err: 1'b0, exp_fv: 1'b0};
        vecs[4] = '{op: 8'h00, exp_err: 1'b1, exp_fv: 1'b0};
        vecs[5] = '{op: 8'h06, exp_err: 1'b1, exp_fv: 1'b0};
        vecs[6] = '{op: 8'h05, exp_err: 1'b0, exp_fv: 1'b0};
        vecs[7] = '{op: 8'hFF, exp_err: 1'b1, exp_fv: 1'b0};
        vecs[8] = '{op: 8'h05, exp_err: 1'b0, exp_fv: 1'b0};
        exp1 = pat_model(1, 0);
        exp2 = pat_model(37, 11);

        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = '0;
        busy       = 1'b0;

        // Reset state
        repeat (2) tick();
        chk_pat("rst_data_reg", data_reg, '0);
        chk("rst_trig", trig, 0);
        chk("rst_clr_mode", clr_mode, 0);
        chk("rst_clr_2_one", clr_2_one, 0);
        chk("rst_err", err, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_ready_low", byte_ready, 0);
        @(negedge clk_in);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", byte_ready, 1);

        // Single-opcode IDLE vectors
        for (int i = 0; i < 9; i++) begin
            send_byte(vecs[i].op);
            chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            chk($sformatf("vec%0d_fv", i), frame_valid, vecs[i].exp_fv);
            chk($sformatf("vec%0d_ready", i), byte_ready, 1);
            tick();
            chk($sformatf("vec%0d_trig", i), trig, 0);
        end

        // LOAD 0x00..0x4D, FIRE with busy low
        load_frame(1, 0);
        send_byte(8'h02);
        chk("fire_ready_low", byte_ready, 0);
        chk_pat("fire_not_yet_committed", data_reg, '0);
        chk("fire_trig_n", trig, 0);
        tick();
        chk_pat("fire_data_reg", data_reg, exp1);
        chk("fire_byte0", 32'(data_reg[7:0]), 32'h00);
        chk("fire_byte1", 32'(data_reg[15:8]), 32'h01);
        chk("fire_top_nibble", 32'(data_reg[619:616]), 32'hD);
        chk("fire_clr_mode", clr_mode, 0);
        chk("fire_trig_n1", trig, 0);
        tick();
        chk("fire_trig_n2", trig, 1);
        busy = 1'b1;
        tick();
        chk("fire_trig_n3", trig, 0);
        tick();
        chk("ack_sync_wait", byte_ready, 0);
        tick();
        chk("ack_sync_exit", byte_ready, 1);
        chk("ack_err", err, 0);

        // Reload shadow while shifter busy, FIRE held off for 50 cycles
        load_frame(37, 11);
        send_byte(8'h02);
        for (int c = 0; c < 50; c++) begin
            chk("hold_ready", byte_ready, 0);
            chk("hold_trig", trig, 0);
            chk_pat("hold_data_reg", data_reg, exp1);
            tick();
        end
        @(negedge clk_in);
        busy = 1'b0;
        tick();
        chk_pat("release_e0_data", data_reg, exp1);
        tick();
        chk_pat("release_e1_data", data_reg, exp1);
        chk("release_e1_trig", trig, 0);
        tick();
        chk_pat("release_e2_data", data_reg, exp2);
        chk("release_e2_trig", trig, 0);
        tick();
        chk("release_e3_trig", trig, 1);
        ack_and_idle();

        // CLEAR_ONE with no acknowledge: ack timeout sets err
        send_byte(8'h04);
        chk("clr1_pre_mode", clr_mode, 0);
        tick();
        chk("clr1_mode", clr_mode, 1);
        chk("clr1_level", clr_2_one, 1);
        chk_pat("clr1_data_kept", data_reg, exp2);
        tick();
        chk("clr1_trig", trig, 1);
        for (int c = 3; c <= 9; c++) begin
            tick();
            chk("clr1_trig_once", trig, 0);
            chk("clr1_err_pending", err, 0);
        end
        chk("clr1_still_waiting", byte_ready, 0);
        tick();
        chk("clr1_timeout_err", err, 1);
        chk("clr1_timeout_idle", byte_ready, 1);
        send_byte(8'h05);
        chk("clr_err_op", err, 0);

        // CLEAR_ZERO, then a pattern FIRE returns clr_mode to 0
        send_byte(8'h03);
        tick();
        chk("clr0_mode", clr_mode, 1);
        chk("clr0_level", clr_2_one, 0);
        tick();
        chk("clr0_trig", trig, 1);
        ack_and_idle();
        send_byte(8'h02);
        tick();
        chk("pat_clr_mode", clr_mode, 0);
        chk("pat_clr_level_kept", clr_2_one, 0);
        chk_pat("pat_data", data_reg, exp2);
        tick();
        chk("pat_trig", trig, 1);
        ack_and_idle();

        // Non-reset values everywhere, then reset mid-LOAD
        send_byte(8'h04);
        tick();
        tick();
        chk("pre_rst_trig", trig, 1);
        ack_and_idle();
        send_byte(8'h7F);
        chk("pre_rst_err", err, 1);
        send_byte(8'h01);
        send_payload(3, 1, 40);
        @(negedge clk_in);
        #2;
        rst = 1'b1;
        #1;
        chk_pat("midrst_data_reg", data_reg, '0);
        chk("midrst_clr_mode", clr_mode, 0);
        chk("midrst_clr_2_one", clr_2_one, 0);
        chk("midrst_trig", trig, 0);
        chk("midrst_fv", frame_valid, 0);
        chk("midrst_err", err, 0);
        chk("midrst_ready", byte_ready, 0);
        @(negedge clk_in);
        rst = 1'b0;
        tick();
        chk("midrst_ready_after", byte_ready, 1);
        send_byte(8'h02);
        chk("post_rst_fire_err", err, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_no_trig", trig, 0);
            chk("post_rst_idle", byte_ready, 1);
        end

`ifdef DIN_LOADER_CHKSUM_EN
        send_byte(8'h05);
        send_byte(8'h01);
        send_payload(5, 3, NB);
        send_chk(5, 3, 1'b1);
        chk("badchk_err", err, 1);
        chk("badchk_fv", frame_valid, 0);
        send_byte(8'h02);
        chk("badchk_fire_idle", byte_ready, 1);
        tick();
        tick();
        chk("badchk_no_trig", trig, 0);
        send_byte(8'h05);
        chk("badchk_err_clr", err, 0);
        load_frame(5, 3);
        chk("goodchk_fv", frame_valid, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
